alu_writeback_stage: RTL
========================

# alu_writeback_stage

Execute-to-writeback stage directly downstream of the 32-bit ALU. It accepts one ALU result per handshake together with its carry/zero/negative/overflow outputs. It checks the instruction's condition code against the architectural NZCV flag register and updates that register. Passing register writes are buffered in a 2-entry FIFO that drives the register-file write port.

## Interface
- DATA_W, 32, ALU result / writeback data width
- RD_W, 5, destination register index width
- CNT_W, 16, width of the retired and squashed counters
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  upstream has an ALU result this cycle
- in_ready  out  1  stage can accept; equals rst_n && (fifo_count < 2)
- in_result  in  DATA_W  ALU result
- in_carry, in_zero, in_negative, in_overflow  in  1 each  ALU flag outputs
- in_rd  in  RD_W  destination register
- in_wen  in  1  instruction writes in_rd
- in_set_flags  in  1  instruction updates NZCV
- in_cond  in  4  condition code (encoding below)
- wb_valid  out  1  head FIFO entry valid
- wb_ready  in  1  register file takes head entry
- wb_rd  out  RD_W  head entry destination
- wb_data  out  DATA_W  head entry data
- flags  out  4  architectural {N,Z,C,V}
- retired_cnt  out  CNT_W  accepted instructions whose condition passed
- squashed_cnt  out  CNT_W  accepted instructions whose condition failed

## Operation
- Accept = in_valid && in_ready. Nothing is sampled when there is no accept.
- Condition is evaluated against the current flags register, meaning the value before this instruction's own update:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&&!Z
  - 9 LS: !C||Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&&(N==V)
  - 13 LE: Z||(N!=V)
  - 14 AL: 1
  - 15 NV: 0
- Pass and in_set_flags: flags <= {in_negative, in_zero, in_carry, in_overflow} at the accept edge.
- Pass and in_wen and in_rd != 0: push {in_rd, in_result} into the FIFO. Writes to register 0 are dropped silently.
- Pass: retired_cnt increments by 1. Fail: squashed_cnt increments by 1, with no flag update and no push.
- Both counters saturate at all-ones.
- FIFO:
  - 2 entries, in-order.
  - Pop when wb_valid && wb_ready.
  - wb_rd and wb_data show the head entry; wb_valid = (fifo_count != 0).
  - Push and pop in the same cycle are legal, and count is unchanged.
  - A push is only possible when count < 2, so there is no overflow case.
- A dropped accept still consumes a handshake. This covers an instruction with no write, a write to register 0, or a squash.

## Timing
- Reset, applied at any rising edge with rst_n = 0, sets:
  - fifo_count = 0, wb_valid = 0, wb_rd = 0, wb_data = 0
  - flags = 4'b0000, retired_cnt = 0, squashed_cnt = 0
- in_ready is 0 throughout reset, including mid-operation. Buffered entries are discarded.
- Latency: an entry accepted at edge N appears with wb_valid = 1 in the cycle after edge N. This holds even if the FIFO was empty.
- Flag hazard: the flags written at edge N are used by a condition evaluated for an accept at edge N+1. Back-to-back dependent instructions need no bubble.
- in_ready depends only on registered state and rst_n. There is no combinational path from wb_ready to in_ready.
  - Consequence: when full, a pop at edge N re-opens in_ready only in cycle N+1.
- wb_rd and wb_data hold stable while wb_valid && !wb_ready.
- Upstream must hold its in_* signals stable while in_valid && !in_ready.

## Test plan
- Reset, then accept ADD {result=25, rd=3, wen=1, set_flags=1, C=0, Z=0, N=0, V=0, cond=AL} with wb_ready=1:
  - wb_valid=1 for one cycle with wb_rd=3, wb_data=25
  - flags=0000, retired_cnt=1
- Accept SUB 20-20 (Z=1, C=1, set_flags=1, wen=0), then the next cycle accept {result=7, rd=4, cond=EQ}:
  - no writeback for the SUB, flags=0110
  - EQ passes and writes rd 4 = 7
  - a following cond=NE instruction squashes: squashed_cnt=1, no wb, flags unchanged
- wb_ready=0, with three back-to-back accepts offered (rd=1, 2, 3):
  - first two accepted, then in_ready=0
  - raise wb_ready: data drains as rd 1 then 2; rd 3 accepted one cycle after the first pop
- FIFO holds 1 entry, wb_ready=1 and a new accept in the same cycle: count stays 1 and order is preserved.
- Accept with in_rd=0, wen=1, cond=AL: no wb_valid, retired_cnt increments.
- Drive rst_n=0 for one edge while the FIFO holds 2 entries and flags=1001: all outputs return to their reset values, and in_ready=1 after rst_n rises.

Source files
------------

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: condition check, NZCV update and 2-entry writeback FIFO after the ALU
module alu_writeback_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_overflow,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  input  logic              in_set_flags,
  input  logic [3:0]        in_cond,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic [CNT_W-1:0]  retired_cnt,
  output logic [CNT_W-1:0]  squashed_cnt
);
  logic [RD_W+DATA_W-1:0] mem [2];
  logic head;
  logic [1:0] count;
  logic n, z, c, v, pass, accept, push, pop, tail;
  logic [15:0] tbl;
  assign {n, z, c, v} = flags;
  assign tbl = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                ~v, v, ~n, n, ~c, c, ~z, z};
  assign pass = tbl[in_cond];
  assign in_ready = rst_n && count != 2'd2;
  assign accept = in_valid && in_ready;
  assign push = accept && pass && in_wen && in_rd != '0;
  assign wb_valid = count != 2'd0;
  assign pop = wb_valid && wb_ready;
  assign tail = head ^ count[0];
  assign {wb_rd, wb_data} = mem[head];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head <= 1'b0;
      count <= 2'd0;
      flags <= 4'b0000;
      retired_cnt <= '0;
      squashed_cnt <= '0;
    end else begin
      if (push) mem[tail] <= {in_rd, in_result};
      if (pop) head <= ~head;
      count <= count + 2'(push) - 2'(pop);
      if (accept && pass && in_set_flags) flags <= {in_negative, in_zero, in_carry, in_overflow};
      if (accept && pass && ~&retired_cnt) retired_cnt <= retired_cnt + CNT_W'(1);
      if (accept && !pass && ~&squashed_cnt) squashed_cnt <= squashed_cnt + CNT_W'(1);
    end
  end
endmodule
